// File: rtl/axis_fifo_reader.sv
// Drains whole packets of cfg_data words from an AXI4-Stream FIFO once enough words are buffered.
// Optional idle-timeout flush of short packets: define AXIS_FIFO_READER_FLUSH_EN.
module axis_fifo_reader #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int CNTR_WIDTH       = 16
`ifdef AXIS_FIFO_READER_FLUSH_EN
  ,
  parameter int FLUSH_CYCLES     = 1024
`endif
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [CNTR_WIDTH-1:0]       cfg_data,
  input  logic [15:0]                 fifo_count,
  output logic [31:0]                 sts_data,
`ifdef AXIS_FIFO_READER_FLUSH_EN
  output logic [31:0]                 flush_count,
`endif
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast
);

  localparam int CMP_W = (CNTR_WIDTH > 16) ? CNTR_WIDTH : 16;
  localparam logic [CNTR_WIDTH-1:0] ONE = CNTR_WIDTH'(1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                      state_q, state_d;
  logic [CNTR_WIDTH-1:0]       cnt_q, cnt_d;
  logic [CNTR_WIDTH-1:0]       len_q, len_d;
  logic [AXIS_TDATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                        tvalid_q, tvalid_d;
  logic                        tlast_q, tlast_d;
  logic [31:0]                 sts_q, sts_d;
  logic                        s_ready;

  // Compare in a width wide enough for both operands so long lengths never wrap.
  logic [CMP_W-1:0] count_ext, cfg_ext;
  logic             start_full;
  assign count_ext  = CMP_W'(fifo_count);
  assign cfg_ext    = CMP_W'(cfg_data);
  assign start_full = (cfg_data != '0) && (count_ext >= cfg_ext);

`ifdef AXIS_FIFO_READER_FLUSH_EN
  localparam logic [CNTR_WIDTH-1:0] FLUSH_LAST = CNTR_WIDTH'(FLUSH_CYCLES - 1);
  logic [CNTR_WIDTH-1:0] timer_q, timer_d;
  logic [31:0]           flush_q, flush_d;
  logic                  flush_cond, flush_go;
  assign flush_cond = (state_q == IDLE) && (count_ext != '0) && (count_ext < cfg_ext);
  assign flush_go   = flush_cond && (timer_q == FLUSH_LAST);
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    sts_d    = sts_q;
    s_ready  = 1'b0;
`ifdef AXIS_FIFO_READER_FLUSH_EN
    timer_d  = '0;
    flush_d  = flush_q;
    if (flush_cond && !flush_go) begin
      timer_d = timer_q + ONE;
    end
`endif

    // Drain first; a same-cycle load below overrides the clear.
    if (tvalid_q && m_axis_tready) begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
      if (tlast_q) begin
        sts_d = sts_q + 32'd1;
      end
    end

    case (state_q)
      IDLE: begin
        if (start_full) begin
          len_d   = cfg_data;
          cnt_d   = '0;
          state_d = BURST;
        end
`ifdef AXIS_FIFO_READER_FLUSH_EN
        else if (flush_go) begin
          len_d   = count_ext[CNTR_WIDTH-1:0];
          cnt_d   = '0;
          state_d = BURST;
          flush_d = flush_q + 32'd1;
        end
`endif
      end
      BURST: begin
        s_ready = ~tvalid_q | m_axis_tready;
        if (s_ready && s_axis_tvalid) begin
          tdata_d  = s_axis_tdata;
          tvalid_d = 1'b1;
          tlast_d  = (cnt_q == len_q - ONE);
          cnt_d    = cnt_q + ONE;
          if (cnt_q == len_q - ONE) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      len_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      sts_q    <= '0;
`ifdef AXIS_FIFO_READER_FLUSH_EN
      timer_q  <= '0;
      flush_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      sts_q    <= sts_d;
`ifdef AXIS_FIFO_READER_FLUSH_EN
      timer_q  <= timer_d;
      flush_q  <= flush_d;
`endif
    end
  end

  assign s_axis_tready = s_ready;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign sts_data      = sts_q;
`ifdef AXIS_FIFO_READER_FLUSH_EN
  assign flush_count   = flush_q;
`endif

endmodule

// File: doc/axis_fifo_reader.md
Name: axis_fifo_reader

Overview:
Drain-side companion for the team's AXI4-Stream FIFO. Takes the FIFO master stream plus its occupancy count, and waits until a full packet of cfg_data words is buffered. It then forwards exactly that many words downstream through a registered output stage and marks the final word with tlast. It feeds DMA writers and packet-oriented consumers that need contiguous, framed bursts.

Parameters:
AXIS_TDATA_WIDTH, 32, data width of both streams
CNTR_WIDTH, 16, width of packet-length config and beat counter
FLUSH_CYCLES, 1024, idle timeout in cycles; used only when AXIS_FIFO_READER_FLUSH_EN is defined

Ports:
aclk  input  1  clock; all logic on rising edge
areset  input  1  reset, synchronous, active-high
cfg_data  input  CNTR_WIDTH  packet length in words; 0 = disabled
fifo_count  input  16  words available upstream (FIFO read_count)
sts_data  output  32  completed-packet counter
s_axis_tdata  input  AXIS_TDATA_WIDTH  upstream data
s_axis_tvalid  input  1  upstream valid
s_axis_tready  output  1  upstream ready
m_axis_tdata  output  AXIS_TDATA_WIDTH  downstream data (registered)
m_axis_tvalid  output  1  downstream valid (registered)
m_axis_tready  input  1  downstream ready
m_axis_tlast  output  1  last word of packet (registered)

Behaviour:
- Interface: one clock, aclk. Reset areset is synchronous and active-high.
- Reset values: state IDLE, beat counter 0, latched length 0, m_axis_tvalid 0, m_axis_tlast 0, m_axis_tdata 0, sts_data 0, s_axis_tready 0.
- FSM states: IDLE, BURST.
- In IDLE:
  - s_axis_tready = 0.
  - If cfg_data != 0 and fifo_count >= cfg_data (unsigned, fifo_count zero-extended to the compare width), latch len = cfg_data, clear the counter, and go to BURST next cycle.
- In BURST:
  - s_axis_tready = ~m_axis_tvalid | m_axis_tready. This gives full throughput: one word per cycle when the sink is always ready.
  - On an input handshake, the word is loaded into the output register with m_axis_tvalid = 1 and tlast = (cnt == len-1), and cnt increments.
  - The handshake with cnt == len-1 returns the FSM to IDLE.
- Output register:
  - On a downstream handshake with no simultaneous load, m_axis_tvalid clears.
  - m_axis_tdata, m_axis_tvalid and m_axis_tlast are held stable while m_axis_tvalid = 1 and m_axis_tready = 0.
- Latency: input handshake to m_axis_tvalid is 1 cycle.
- Packet spacing: at least 1 idle input cycle between packets, because IDLE re-evaluates fifo_count. Output of packet N may still be draining while IDLE evaluates packet N+1.
- cfg_data changes during BURST are ignored; the latched len governs. A new value takes effect at the next IDLE evaluation.
- s_axis_tvalid low mid-burst: the block stalls, with no timeout in BURST.
- fifo_count is not rechecked during BURST.
- sts_data increments by 1 on every downstream handshake with m_axis_tlast = 1, and wraps 0xFFFFFFFF -> 0.
- Reset mid-burst: the partial packet is abandoned, outputs return to reset values, and sts_data is not incremented.
- CNTR_WIDTH > 16: fifo_count is compared zero-extended, so lengths above 65535 never start.

Optional Feature:
AXIS_FIFO_READER_FLUSH_EN
- Defined:
  - A CNTR_WIDTH-wide idle timer runs in IDLE while 0 < fifo_count < cfg_data. It clears when either condition fails or when a burst starts.
  - When the timer reaches FLUSH_CYCLES, the block latches len = fifo_count and enters BURST. The result is a short packet with tlast on its final word.
  - A second 32-bit status output is added: flush_count, which increments per short packet.
- Not defined:
  - No timer, no flush_count port.
  - A partial packet stays in the FIFO indefinitely.

Test Plan:
- cfg_data=8, fifo_count=8, s_axis_tvalid=1, words 0..7, m_axis_tready=1 -> 8 output beats on consecutive cycles, first beat 1 cycle after first s handshake; tlast only on word 7; sts_data=1.
- cfg_data=4, fifo_count=3 for 100 cycles, then 4 -> s_axis_tready stays 0 while count=3; exactly 4 beats after count=4; tlast on the 4th.
- cfg_data=4, m_axis_tready toggling 1,0,0,1,... -> data/tvalid/tlast held stable during stalls; no word lost or duplicated; output sequence equals input sequence.
- cfg_data=4, change cfg_data to 2 after beat 1 -> current packet still 4 beats; next packet 2 beats; sts_data=2 after both.
- areset pulsed after beat 2 of an 8-word packet -> next cycle m_axis_tvalid=0, tlast=0, sts_data=0, state IDLE; the following packet is framed correctly from its first word.
- With AXIS_FIFO_READER_FLUSH_EN, FLUSH_CYCLES=16, cfg_data=8, fifo_count=3 -> burst starts after 16 idle cycles; 3 beats with tlast on the 3rd; flush_count=1, sts_data=1.
